// File: rtl/qed_fetch_responder_if.sv
// Bundle of the generator push port, the DUT fetch port and the status
// outputs of the fetch responder. The harness side uses 'master'; the
// responder itself uses 'slave'.
interface qed_fetch_responder_if #(
    parameter int DEPTH = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // generator push side
    logic             in_valid;
    logic [31:0]      in_inst;
    logic             in_ready;
    // harness restart
    logic             flush;
    // DUT fetch side
    logic             r_enable;
    logic [63:0]      r_index;
    logic [63:0]      r_data_0;
    logic [63:0]      r_data_1;
    logic [63:0]      r_data_2;
    logic [63:0]      r_data_3;
    logic             rsp_valid;
    // status
    logic [CNT_W-1:0] fifo_count;
    logic [15:0]      underflow_cnt;

    modport master (
        output in_valid, in_inst, flush, r_enable, r_index,
        input  in_ready, r_data_0, r_data_1, r_data_2, r_data_3,
               rsp_valid, fifo_count, underflow_cnt
    );

    modport slave (
        input  in_valid, in_inst, flush, r_enable, r_index,
        output in_ready, r_data_0, r_data_1, r_data_2, r_data_3,
               rsp_valid, fifo_count, underflow_cnt
    );
endinterface

// File: rtl/qed_fetch_responder.sv
// Memory-side responder for the instruction-fetch read port. Instructions
// from the QED generator are buffered in a FIFO; each fetch of a new index
// pops one instruction, and a small index/instruction history replays the
// same bits when the core re-fetches an index it has already been served.
module qed_fetch_responder #(
    parameter int          DEPTH    = 8,
    parameter int          HIST     = 4,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                   clock,
    input  logic                   reset_n,
    qed_fetch_responder_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int HP_W  = (HIST > 1) ? $clog2(HIST) : 1;

    // FIFO storage and bookkeeping
    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // replay history
    logic [HIST-1:0]  hist_valid_q, hist_valid_d;
    logic [63:0]      hist_idx_q  [HIST];
    logic [31:0]      hist_inst_q [HIST];
    logic [HP_W-1:0]  hist_ptr_q, hist_ptr_d;
    logic [HIST-1:0]  hist_match;

    // response and statistics
    logic [31:0]      r_inst_q, r_inst_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [15:0]      uf_cnt_q, uf_cnt_d;

    // per-cycle decisions
    logic             fifo_empty;
    logic             fifo_ready;
    logic             req_ok;
    logic             hit;
    logic [31:0]      hit_inst;
    logic [31:0]      head_inst;
    logic             do_push;
    logic             do_pop;
    logic             do_nop;

    // Full 64-bit index compare against every valid history entry
    genvar gi;
    generate
        for (gi = 0; gi < HIST; gi++) begin : g_hist_match
            assign hist_match[gi] = hist_valid_q[gi] && (hist_idx_q[gi] == bus.r_index);
        end
    endgenerate

    // Priority select among matching entries: lowest entry number wins
    always_comb begin
        hit      = 1'b0;
        hit_inst = '0;
        for (int i = HIST - 1; i >= 0; i--) begin
            if (hist_match[i]) begin
                hit      = 1'b1;
                hit_inst = hist_inst_q[i];
            end
        end
    end

    assign head_inst  = mem_q[rd_ptr_q];
    assign fifo_empty = (count_q == '0);
    assign fifo_ready = (count_q < CNT_W'(DEPTH));

    // Classify the request on pre-edge state and compute all next values;
    // flush suppresses every push, pop and response in its cycle
    always_comb begin
        req_ok  = bus.r_enable && !bus.flush;
        do_pop  = req_ok && !hit && !fifo_empty;
        do_nop  = req_ok && !hit && fifo_empty;
        do_push = bus.in_valid && fifo_ready && !bus.flush;

        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        hist_valid_d = hist_valid_q;
        hist_ptr_d   = hist_ptr_q;
        r_inst_d     = r_inst_q;
        rsp_valid_d  = req_ok;
        uf_cnt_d     = uf_cnt_q;

        if (bus.flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            hist_valid_d = '0;
            hist_ptr_d   = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                hist_valid_d[hist_ptr_q] = 1'b1;
                hist_ptr_d = (hist_ptr_q == HP_W'(HIST - 1)) ? '0 : hist_ptr_q + HP_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);

            if (hit && req_ok) begin
                r_inst_d = hit_inst;
            end else if (do_pop) begin
                r_inst_d = head_inst;
            end else if (do_nop) begin
                r_inst_d = NOP_INST;
                if (uf_cnt_q != 16'hFFFF) begin
                    uf_cnt_d = uf_cnt_q + 16'd1;
                end
            end
        end
    end

    // FIFO payload storage; contents are meaningless until pushed, so no reset
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= bus.in_inst;
        end
    end

    // History payload: the popped head is recorded under the fetch index
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < HIST; i++) begin
                hist_idx_q[i]  <= '0;
                hist_inst_q[i] <= '0;
            end
        end else if (do_pop) begin
            for (int i = 0; i < HIST; i++) begin
                if (hist_ptr_q == HP_W'(i)) begin
                    hist_idx_q[i]  <= bus.r_index;
                    hist_inst_q[i] <= head_inst;
                end
            end
        end
    end

    // Control and response state registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            hist_valid_q <= '0;
            hist_ptr_q   <= '0;
            r_inst_q     <= NOP_INST;
            rsp_valid_q  <= 1'b0;
            uf_cnt_q     <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            hist_valid_q <= hist_valid_d;
            hist_ptr_q   <= hist_ptr_d;
            r_inst_q     <= r_inst_d;
            rsp_valid_q  <= rsp_valid_d;
            uf_cnt_q     <= uf_cnt_d;
        end
    end

    assign bus.in_ready      = fifo_ready;
    assign bus.r_data_0      = {r_inst_q, r_inst_q};
    assign bus.r_data_1      = {r_inst_q, r_inst_q};
    assign bus.r_data_2      = {r_inst_q, r_inst_q};
    assign bus.r_data_3      = {r_inst_q, r_inst_q};
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.fifo_count    = count_q;
    assign bus.underflow_cnt = uf_cnt_q;
endmodule

// File: tb/tb_qed_fetch_responder.sv
// Bench for qed_fetch_responder: directed scenarios followed by random
// traffic, all compared every cycle against a queue-based reference model.
module tb_qed_fetch_responder;
    localparam int          DEPTH = 8;
    localparam int          HIST  = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    localparam logic [31:0] INST_A = 32'h0010_0093;
    localparam logic [31:0] INST_B = 32'h0020_0113;
    localparam logic [31:0] INST_C = 32'h0030_0193;
    localparam logic [31:0] INST_D = 32'h0040_0213;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    qed_fetch_responder_if #(.DEPTH(DEPTH)) bus ();

    qed_fetch_responder #(
        .DEPTH    (DEPTH),
        .HIST     (HIST),
        .NOP_INST (NOP)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    typedef struct packed {
        logic [63:0] idx;
        logic [31:0] inst;
    } hent_t;

    logic [31:0] m_fifo [$];
    hent_t       m_hist [$];
    logic [31:0] m_inst;
    logic        m_rsp;
    int          m_uf;

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_hist.delete();
        m_inst = NOP;
        m_rsp  = 1'b0;
        m_uf   = 0;
    endtask

    task automatic drive_idle();
        bus.in_valid = 1'b0;
        bus.in_inst  = '0;
        bus.flush    = 1'b0;
        bus.r_enable = 1'b0;
        bus.r_index  = '0;
    endtask

    task automatic check_all();
        chk_val("rsp_valid",     64'(bus.rsp_valid),     64'(m_rsp));
        chk_val("r_data_0",      bus.r_data_0,           {m_inst, m_inst});
        chk_val("r_data_1",      bus.r_data_1,           {m_inst, m_inst});
        chk_val("r_data_2",      bus.r_data_2,           {m_inst, m_inst});
        chk_val("r_data_3",      bus.r_data_3,           {m_inst, m_inst});
        chk_val("fifo_count",    64'(bus.fifo_count),    64'(m_fifo.size()));
        chk_val("in_ready",      64'(bus.in_ready),      64'(m_fifo.size() < DEPTH));
        chk_val("underflow_cnt", 64'(bus.underflow_cnt), 64'(m_uf));
    endtask

    // One clock of stimulus: model advances on the pre-edge state, DUT is
    // sampled 1ns after the edge and compared against the model.
    task automatic step(input logic en, input logic [63:0] idx,
                        input logic pv, input logic [31:0] pd, input logic fl);
        bit          ready;
        bit          found;
        logic [31:0] got;
        hent_t       h;

        bus.r_enable = en;
        bus.r_index  = idx;
        bus.in_valid = pv;
        bus.in_inst  = pd;
        bus.flush    = fl;

        ready = (m_fifo.size() < DEPTH);
        found = 1'b0;
        got   = '0;
        if (fl) begin
            m_fifo.delete();
            m_hist.delete();
            m_rsp = 1'b0;
        end else begin
            m_rsp = en;
            if (en) begin
                foreach (m_hist[k]) begin
                    if (m_hist[k].idx == idx) begin
                        found = 1'b1;
                        got   = m_hist[k].inst;
                    end
                end
                if (found) begin
                    m_inst = got;
                end else if (m_fifo.size() > 0) begin
                    m_inst = m_fifo.pop_front();
                    h.idx  = idx;
                    h.inst = m_inst;
                    m_hist.push_back(h);
                    if (m_hist.size() > HIST) void'(m_hist.pop_front());
                end else begin
                    m_inst = NOP;
                    if (m_uf < 65535) m_uf++;
                end
            end
            if (pv && ready) m_fifo.push_back(pd);
        end

        @(posedge clock);
        #1;
        $display("txn en=%0d idx=%h push=%0d data=%h flush=%0d -> rsp=%0d r_data=%h cnt=%0d uf=%0d",
                 en, idx, pv, pd, fl, bus.rsp_valid, bus.r_data_0, bus.fifo_count, bus.underflow_cnt);
        check_all();
    endtask

    logic [63:0] idx_pool [8];
    logic [31:0] vals [6];

    initial begin
        idx_pool[0] = 64'h0000_0000_0000_0005;
        idx_pool[1] = 64'h0000_0100_0000_0005;
        idx_pool[2] = 64'h8000_0000_0000_0005;
        idx_pool[3] = 64'h0000_0000_0000_0010;
        idx_pool[4] = 64'h0000_0000_0000_0020;
        idx_pool[5] = 64'h0000_0000_0000_0024;
        idx_pool[6] = 64'hFFFF_FFFF_FFFF_FFFF;
        idx_pool[7] = 64'h0000_0000_0000_0000;

        // reset state
        reset_n = 1'b0;
        drive_idle();
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all();
        reset_n = 1'b1;

        // two pushes then two fresh indices
        step(1'b0, 64'h0, 1'b1, INST_A, 1'b0);
        step(1'b0, 64'h0, 1'b1, INST_B, 1'b0);
        step(1'b1, 64'h10, 1'b0, 32'h0, 1'b0);
        chk_val("tp_first_a", bus.r_data_0, {INST_A, INST_A});
        step(1'b1, 64'h20, 1'b0, 32'h0, 1'b0);
        chk_val("tp_first_b", bus.r_data_0, {INST_B, INST_B});
        chk_val("tp_drained", 64'(bus.fifo_count), 64'd0);

        // replay hit, then a new index after a push
        step(1'b1, 64'h10, 1'b0, 32'h0, 1'b0);
        chk_val("tp_replay_a", bus.r_data_0, {INST_A, INST_A});
        step(1'b0, 64'h0, 1'b1, INST_C, 1'b0);
        step(1'b1, 64'h30, 1'b0, 32'h0, 1'b0);
        chk_val("tp_new_c", bus.r_data_0, {INST_C, INST_C});

        // underflow with a simultaneous push, no bypass
        step(1'b1, 64'h40, 1'b1, INST_D, 1'b0);
        chk_val("tp_underflow_nop", bus.r_data_0, {NOP, NOP});
        chk_val("tp_underflow_cnt", 64'(bus.underflow_cnt), 64'd1);
        step(1'b1, 64'h50, 1'b0, 32'h0, 1'b0);
        chk_val("tp_after_nop_d", bus.r_data_0, {INST_D, INST_D});

        // fill beyond capacity, then pop-only and pop+push
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 64'h0, 1'b1, $urandom, 1'b0);
        chk_val("tp_full_count", 64'(bus.fifo_count), 64'(DEPTH));
        chk_val("tp_full_ready", 64'(bus.in_ready), 64'd0);
        step(1'b1, 64'h60, 1'b0, 32'h0, 1'b0);
        step(1'b1, 64'h70, 1'b1, $urandom, 1'b0);
        chk_val("tp_pop_push_cnt", 64'(bus.fifo_count), 64'(DEPTH - 1));

        // history eviction with HIST entries
        step(1'b0, 64'h0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            vals[i] = $urandom;
            step(1'b0, 64'h0, 1'b1, vals[i], 1'b0);
        end
        for (int i = 0; i < 5; i++) step(1'b1, 64'h100 + 64'(i), 1'b0, 32'h0, 1'b0);
        step(1'b1, 64'h100, 1'b0, 32'h0, 1'b0);
        chk_val("tp_evicted_pop", bus.r_data_0, {vals[5], vals[5]});
        chk_val("tp_evicted_cnt", 64'(bus.fifo_count), 64'd0);
        step(1'b1, 64'h104, 1'b0, 32'h0, 1'b0);
        chk_val("tp_i4_hit", bus.r_data_0, {vals[4], vals[4]});

        // flush with entries buffered and a request pending
        for (int i = 0; i < 3; i++) step(1'b0, 64'h0, 1'b1, $urandom, 1'b0);
        step(1'b1, 64'h104, 1'b0, 32'h0, 1'b1);
        chk_val("tp_flush_rsp", 64'(bus.rsp_valid), 64'd0);
        chk_val("tp_flush_cnt", 64'(bus.fifo_count), 64'd0);
        step(1'b1, 64'h104, 1'b0, 32'h0, 1'b0);
        chk_val("tp_flush_old_nop", bus.r_data_0, {NOP, NOP});

        // random traffic
        for (int n = 0; n < 600; n++) begin
            step(1'($urandom_range(0, 1)),
                 idx_pool[$urandom_range(0, 7)],
                 1'($urandom_range(0, 1)),
                 $urandom,
                 1'($urandom_range(0, 49) == 0));
        end

        // asynchronous reset in the middle of a request
        step(1'b0, 64'h0, 1'b1, INST_B, 1'b0);
        step(1'b1, 64'h900, 1'b1, INST_C, 1'b0);
        bus.r_enable = 1'b1;
        bus.r_index  = 64'h901;
        bus.in_valid = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk_val("tp_async_rdata", bus.r_data_0, {NOP, NOP});
        check_all();
        drive_idle();
        @(negedge clock);
        reset_n = 1'b1;
        step(1'b1, 64'h902, 1'b0, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
